// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W           = 4;
    localparam int unsigned DEF_MEM_TIMEOUT = 255;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r;
        logic [REG_W-1:0] dest;
    } slot_t;

    function automatic logic slot_writes(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid & s.wb_en & (s.dest == r);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW hazard detection of the ID instruction against the EXE/MEM shadow slots.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b0
) (
    input  slot_t            exe_slot,
    input  slot_t            mem_slot,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    output logic             hazard
);

    logic match1;
    logic match2;
    logic unused;

    // With forwarding only a load still in EXE cannot deliver its data in time.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        if (FORWARD_EN) begin
            match1 = exe_slot.valid & exe_slot.mem_r & (exe_slot.dest == id_src1);
            match2 = exe_slot.valid & exe_slot.mem_r & (exe_slot.dest == id_src2);
        end else begin
            match1 = slot_writes(exe_slot, id_src1) | slot_writes(mem_slot, id_src1);
            match2 = slot_writes(exe_slot, id_src2) | slot_writes(mem_slot, id_src2);
        end
    end

    assign hazard = id_valid & ((id_use_src1 & match1) | (id_two_src & match2));

    assign unused = ^{mem_slot, exe_slot.mem_r, exe_slot.wb_en};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: hazard stalls, branch
// flushes, memory-busy freeze, timeout flag and performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit          FORWARD_EN  = 1'b0,
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             exe_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             pipe_stall,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned    WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    slot_t             exe_slot;
    slot_t             mem_slot;
    logic              hazard;
    logic              mem_busy;
    logic              do_flush;
    logic              do_stall;

    hazard_detect #(
        .FORWARD_EN(FORWARD_EN)
    ) u_hazard_detect (
        .exe_slot    (exe_slot),
        .mem_slot    (mem_slot),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use_src1 (id_use_src1),
        .id_two_src  (id_two_src),
        .hazard      (hazard)
    );

    // Memory busy dominates; a taken branch squashes the hazarding instruction.
    assign mem_busy = rst & mem_req & ~mem_ready;
    assign do_flush = rst & ~mem_busy & exe_branch_taken;
    assign do_stall = rst & ~mem_busy & ~exe_branch_taken & hazard;

    assign pipe_stall   = mem_busy;
    assign pc_freeze    = mem_busy | do_stall;
    assign ifid_freeze  = mem_busy | do_stall;
    assign ifid_flush   = do_flush;
    assign idexe_bubble = do_flush | do_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_slot <= '0;
            mem_slot <= '0;
        end else if (!pipe_stall) begin
            mem_slot <= '{valid: exe_slot.valid, wb_en: exe_slot.wb_en,
                          mem_r: 1'b0, dest: exe_slot.dest};
            if (idexe_bubble)
                exe_slot <= '0;
            else
                exe_slot <= '{valid: id_valid, wb_en: id_wb_en,
                              mem_r: id_mem_r_en, dest: id_dest};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_req && !mem_ready)
                        state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != TIMEOUT_V) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == TIMEOUT_V - WAIT_W'(1))
                            mem_error <= 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (do_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: vector table on a no-forwarding instance plus corner-case
// sequences on a forwarding instance with narrow counters.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_src1, id_two_src, id_wb_en, id_mem_r_en;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       exe_branch_taken, mem_req, mem_ready;

    logic        a_pc_freeze, a_ifid_freeze, a_ifid_flush, a_idexe_bubble, a_pipe_stall, a_mem_error;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_freeze, b_ifid_freeze, b_ifid_flush, b_idexe_bubble, b_pipe_stall, b_mem_error;
    logic [2:0]  b_stall_cnt, b_flush_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] HZ = 5'b11010;
    localparam logic [4:0] FL = 5'b00110;
    localparam logic [4:0] MB = 5'b11001;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_branch_taken(exe_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(a_pc_freeze),
        .ifid_freeze(a_ifid_freeze), .ifid_flush(a_ifid_flush), .idexe_bubble(a_idexe_bubble),
        .pipe_stall(a_pipe_stall), .mem_error(a_mem_error), .stall_cnt(a_stall_cnt),
        .flush_cnt(a_flush_cnt)
    );

    pipe_hazard_ctrl #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(255), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_branch_taken(exe_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(b_pc_freeze),
        .ifid_freeze(b_ifid_freeze), .ifid_flush(b_ifid_flush), .idexe_bubble(b_idexe_bubble),
        .pipe_stall(b_pipe_stall), .mem_error(b_mem_error), .stall_cnt(b_stall_cnt),
        .flush_cnt(b_flush_cnt)
    );

    typedef struct {
        logic       valid;
        logic [3:0] s1, s2;
        logic       u1, two, wb, mr;
        logic [3:0] dest;
        logic       br, req, rdy;
        logic [4:0] ctrl;
        int         sc, fc;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic valid, input logic [3:0] s1, input logic [3:0] s2,
                                input logic u1, input logic two, input logic wb, input logic mr,
                                input logic [3:0] dest, input logic br, input logic req,
                                input logic rdy, input logic [4:0] ctrl, input int sc, input int fc);
        vec_t v;
        v.valid = valid; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.two = two; v.wb = wb; v.mr = mr;
        v.dest = dest; v.br = br; v.req = req; v.rdy = rdy; v.ctrl = ctrl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_src1 = v.s1; id_src2 = v.s2; id_use_src1 = v.u1;
        id_two_src = v.two; id_wb_en = v.wb; id_mem_r_en = v.mr; id_dest = v.dest;
        exe_branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_a();
        return {a_pc_freeze, a_ifid_freeze, a_ifid_flush, a_idexe_bubble, a_pipe_stall};
    endfunction

    function automatic logic [4:0] ctrl_b();
        return {b_pc_freeze, b_ifid_freeze, b_ifid_flush, b_idexe_bubble, b_pipe_stall};
    endfunction

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NO, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // valid s1 s2 u1 two wb mr dest br req rdy ctrl sc fc
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NO, 0, 0);
        vecs[1]  = mk(1, 2, 0, 1, 0, 1, 0,  1, 0, 0, 0, NO, 0, 0);
        vecs[2]  = mk(1, 1, 0, 1, 0, 1, 0,  3, 0, 0, 0, HZ, 0, 0);
        vecs[3]  = mk(1, 1, 0, 1, 0, 1, 0,  3, 0, 0, 0, HZ, 1, 0);
        vecs[4]  = mk(1, 1, 0, 1, 0, 1, 0,  3, 0, 0, 0, NO, 2, 0);
        vecs[5]  = mk(1, 4, 3, 1, 0, 1, 0,  5, 0, 0, 0, NO, 2, 0);
        vecs[6]  = mk(1, 0, 3, 0, 1, 0, 0,  6, 0, 0, 0, HZ, 2, 0);
        vecs[7]  = mk(1, 0, 3, 0, 1, 0, 0,  6, 0, 0, 0, NO, 3, 0);
        vecs[8]  = mk(0, 6, 0, 1, 0, 0, 0,  6, 0, 0, 0, NO, 3, 0);
        vecs[9]  = mk(1, 8, 0, 1, 0, 1, 0,  7, 0, 0, 0, NO, 3, 0);
        vecs[10] = mk(1, 7, 0, 1, 0, 0, 0,  0, 1, 0, 0, FL, 3, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NO, 3, 1);
        vecs[12] = mk(1, 8, 0, 1, 0, 1, 0,  9, 0, 0, 0, NO, 3, 1);
        vecs[13] = mk(1, 9, 0, 1, 0, 1, 0, 10, 0, 1, 0, MB, 3, 1);
        vecs[14] = mk(1, 9, 0, 1, 0, 1, 0, 10, 0, 1, 0, MB, 3, 1);
        vecs[15] = mk(1, 9, 0, 1, 0, 1, 0, 10, 0, 1, 0, MB, 3, 1);
        vecs[16] = mk(1, 9, 0, 1, 0, 1, 0, 10, 0, 1, 1, HZ, 3, 1);
        vecs[17] = mk(1, 9, 0, 1, 0, 1, 0, 10, 0, 0, 0, HZ, 4, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NO, 5, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, MB, 5, 1);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, FL, 5, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NO, 5, 2);

        rst = 1'b0;
        idle();
        #12;
        check("reset ctrl a", 32'(ctrl_a()), 32'(NO));
        check("reset ctrl b", 32'(ctrl_b()), 32'(NO));
        check("reset counters a", {a_stall_cnt, a_flush_cnt}, 32'h0);
        check("reset mem_error a", 32'(a_mem_error), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d ctrl", i), 32'(ctrl_a()), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d stall_cnt", i), 32'(a_stall_cnt), 32'(vecs[i].sc));
            check($sformatf("vec%0d flush_cnt", i), 32'(a_flush_cnt), 32'(vecs[i].fc));
            check($sformatf("vec%0d mem_error", i), 32'(a_mem_error), 32'h0);
        end

        // Memory timeout: flag rises after the 4th MEM_WAIT cycle, sticky until reset.
        do_reset();
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MB, 0, 0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("timeout pre", 32'(a_mem_error), 32'h0);
        check("timeout busy ctrl", 32'(ctrl_a()), 32'(MB));
        @(negedge clk);
        check("timeout set", 32'(a_mem_error), 32'h1);
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("timeout sticky", 32'(a_mem_error), 32'h1);
        check("timeout released ctrl", 32'(ctrl_a()), 32'(NO));
        rst = 1'b0;
        #1;
        check("timeout cleared by reset", 32'(a_mem_error), 32'h0);
        rst = 1'b1;

        // Reset asserted in the middle of a hazard stall.
        do_reset();
        @(negedge clk);
        drive(mk(1, 2, 0, 1, 0, 1, 0, 1, 0, 0, 0, NO, 0, 0));
        @(negedge clk);
        drive(mk(1, 1, 0, 1, 0, 1, 0, 3, 0, 0, 0, HZ, 0, 0));
        #1;
        check("mid-reset stall 1", 32'(ctrl_a()), 32'(HZ));
        @(negedge clk);
        #1;
        check("mid-reset stall 2", 32'(ctrl_a()), 32'(HZ));
        check("mid-reset stall_cnt", 32'(a_stall_cnt), 32'h1);
        rst = 1'b0;
        #1;
        check("async reset ctrl", 32'(ctrl_a()), 32'(NO));
        check("async reset stall_cnt", 32'(a_stall_cnt), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post-reset no stall", 32'(ctrl_a()), 32'(NO));
        @(negedge clk);
        #1;
        check("post-reset no stall 2", 32'(ctrl_a()), 32'(NO));
        check("post-reset stall_cnt", 32'(a_stall_cnt), 32'h0);

        // Forwarding instance: only load-use stalls, for one cycle.
        do_reset();
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, NO, 0, 0));
        #1;
        check("fwd ldr ctrl", 32'(ctrl_b()), 32'(NO));
        @(negedge clk);
        drive(mk(1, 0, 2, 0, 1, 1, 0, 4, 0, 0, 0, HZ, 0, 0));
        #1;
        check("fwd load-use stall", 32'(ctrl_b()), 32'(HZ));
        @(negedge clk);
        #1;
        check("fwd load-use release", 32'(ctrl_b()), 32'(NO));
        check("fwd stall_cnt", 32'(b_stall_cnt), 32'h1);
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, NO, 0, 0));
        @(negedge clk);
        drive(mk(1, 0, 2, 0, 1, 1, 0, 4, 0, 0, 0, NO, 0, 0));
        #1;
        check("fwd alu-use no stall", 32'(ctrl_b()), 32'(NO));
        @(negedge clk);
        #1;
        check("fwd alu-use stall_cnt", 32'(b_stall_cnt), 32'h1);

        // Nine flushes saturate the 3-bit flush counter at 7.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FL, 0, 0));
        #1;
        check("fwd flush ctrl", 32'(ctrl_b()), 32'(FL));
        repeat (9) @(negedge clk);
        #1;
        check("flush_cnt saturate", 32'(b_flush_cnt), 32'h7);
        check("stall_cnt unchanged", 32'(b_stall_cnt), 32'h1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Keeps shadow copies of the destination info for the EXE and MEM stages.
- Detects RAW hazards against the instruction in ID and squashes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while the data memory is busy. Drives the freeze/flush controls of all pipeline registers and keeps performance counters.

Parameters:
- FORWARD_EN, 0: 1 = a forwarding unit exists, so only load-use hazards stall; 0 = stall on any EXE/MEM destination match.
- MEM_TIMEOUT, 255: maximum number of cycles spent in MEM_WAIT before mem_error is set.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  4  Rn index of the ID instruction.
- id_src2  in  4  Rm/Rd-store index of the ID instruction.
- id_use_src1  in  1  ID instruction reads Rn.
- id_two_src  in  1  ID instruction reads src2.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_r_en  in  1  ID instruction is a load.
- id_dest  in  4  destination register of the ID instruction.
- exe_branch_taken  in  1  branch in EXE is taken (B && condition true).
- mem_req  in  1  MEM stage issues a read or write.
- mem_ready  in  1  data memory completes the request this cycle.
- pc_freeze  out  1  hold the PC.
- ifid_freeze  out  1  hold the IF/ID register.
- ifid_flush  out  1  clear the IF/ID register to a bubble.
- idexe_bubble  out  1  load a bubble into the ID/EXE register.
- pipe_stall  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- mem_error  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  number of hazard-stall cycles.
- flush_cnt  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Reset (rst=0, asynchronous):
  - exe/mem shadow valid=0, state=RUN, wait counter=0, mem_error=0, stall_cnt=0, flush_cnt=0.
  - All control outputs are 0.
- Shadow pipeline (EXE slot: valid, wb_en, mem_r, dest; MEM slot: valid, wb_en, dest):
  - Advances on every clk edge where pipe_stall=0: EXE slot moves to the MEM slot.
  - The EXE slot loads the ID info, or loads valid=0 when idexe_bubble=1.
  - Holds while pipe_stall=1.
- Hazard, combinational, same cycle:
  - match(r) = (exe.valid & exe.wb_en & exe.dest==r) | (mem.valid & mem.wb_en & mem.dest==r).
  - When FORWARD_EN=1, match reduces to exe.valid & exe.mem_r & exe.dest==r.
  - hazard = id_valid & ((id_use_src1 & match(id_src1)) | (id_two_src & match(id_src2))).
- FSM states RUN and MEM_WAIT:
  - RUN to MEM_WAIT when mem_req & ~mem_ready.
  - MEM_WAIT to RUN when mem_ready.
  - The wait counter increments in MEM_WAIT and clears on exit. When it reaches MEM_TIMEOUT, mem_error is set and the FSM stays in MEM_WAIT.
  - mem_error clears only on reset.
- Output priority, all combinational, highest first:
  - Memory busy, (mem_req & ~mem_ready) in either state: pipe_stall=1, pc_freeze=1, ifid_freeze=1, ifid_flush=0, idexe_bubble=0. exe_branch_taken and hazard are ignored; they re-evaluate when the stall releases.
  - Taken branch: ifid_flush=1 and idexe_bubble=1, for one cycle per branch. Freezes are 0, so the PC loads the branch target. A simultaneous hazard is dropped because its instruction is squashed.
  - Hazard: pc_freeze=1, ifid_freeze=1, idexe_bubble=1. Repeats each cycle until the producer leaves MEM: at most 2 cycles when FORWARD_EN=0, 1 cycle when FORWARD_EN=1.
  - Otherwise all controls are 0.
- Counters:
  - stall_cnt increments on each cycle with hazard-stall outputs active.
  - flush_cnt increments on each cycle with branch-flush outputs active.
  - Neither counter increments during pipe_stall. Both saturate at all-ones, with no wrap.
- A src index equal to a bubble's stale dest never matches, because the bubble has valid=0.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum (RUN, MEM_WAIT).
  - Shadow-slot struct {valid, wb_en, mem_r, dest[3:0]}.
  - REG_W=4.
  - Default MEM_TIMEOUT.
- One natural sub-module, hazard_detect: combinational match logic over the shadow slots, parameterised by FORWARD_EN.

Test Plan:
- FORWARD_EN=0, ADD R1 writes R1 then SUB reads R1 as src1 next cycle -> pc_freeze, ifid_freeze and idexe_bubble high for exactly 2 cycles, then 0; stall_cnt=2.
- FORWARD_EN=1, LDR R2 then ADD uses R2 as src2 with id_two_src=1 -> exactly 1 stall cycle. The same sequence with ADD R2 as producer -> 0 stall cycles.
- exe_branch_taken=1 in the same cycle as an ID hazard -> ifid_flush=1, idexe_bubble=1, pc_freeze=0 for 1 cycle; flush_cnt=1, stall_cnt unchanged.
- mem_req=1 with mem_ready low for 3 cycles -> pipe_stall, pc_freeze and ifid_freeze high for 3 cycles, shadow slots unchanged; a hazard present during the wait produces no stall_cnt increments.
- MEM_TIMEOUT=4 with mem_ready never asserted -> mem_error rises after 4 MEM_WAIT cycles and stays 1 after mem_ready later rises; cleared only by rst=0.
- Assert rst=0 mid-hazard-stall -> all outputs 0 immediately (asynchronously); after release, counters are 0 and no stall occurs for an ID instruction matching the pre-reset dest.
